// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory port between instruction fetch and the data stage.
// MEM has default priority; a starvation counter forces an IF grant after STARVE_LIMIT DM wins.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | bus free; choose a requester and latch its request fields
// IF_BUSY | fetch transaction on the bus, waiting for mem_ready
// DM_BUSY | load/store transaction on the bus, waiting for mem_ready
module mem_port_arbiter #(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [2:0]        dm_type,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ready,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [2:0]        mem_type,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2
    } state_t;

    localparam logic [2:0] FETCH_TYPE = 3'b110;
    localparam logic [3:0] LIMIT      = 4'(STARVE_LIMIT);

    state_t     state;
    logic [3:0] starve_cnt;
    logic       drop_fetch;
    logic       grant_if;
    logic       grant_dm;

    // A flush in IDLE only blocks the fetch; a waiting DM request still wins that cycle.
    always_comb begin
        grant_if = 1'b0;
        grant_dm = 1'b0;
        if (state == IDLE) begin
            if (dm_req && if_req && !if_flush && (starve_cnt == LIMIT)) begin
                grant_if = 1'b1;
            end else if (dm_req) begin
                grant_dm = 1'b1;
            end else if (if_req && !if_flush) begin
                grant_if = 1'b1;
            end
        end
    end

    // Ready pulses are combinational from mem_ready so the owner sees completion in the same cycle.
    always_comb begin
        dm_ready = (state == DM_BUSY) && mem_ready;
        if_ready = (state == IF_BUSY) && mem_ready && !drop_fetch && !if_flush;
        dm_rdata = dm_ready ? mem_rdata : '0;
        if_rdata = if_ready ? mem_rdata : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            starve_cnt <= '0;
            drop_fetch <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_type   <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_dm) begin
                        state     <= DM_BUSY;
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_type  <= dm_type;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        if (if_req && (starve_cnt != LIMIT)) begin
                            starve_cnt <= starve_cnt + 4'd1;
                        end
                    end else if (grant_if) begin
                        state      <= IF_BUSY;
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_type   <= FETCH_TYPE;
                        mem_addr   <= if_addr;
                        mem_wdata  <= '0;
                        starve_cnt <= '0;
                    end
                    if (!if_req) begin
                        starve_cnt <= '0;
                    end
                end
                IF_BUSY: begin
                    if (if_flush) begin
                        drop_fetch <= 1'b1;
                    end
                    // Flushed fetches still finish on the bus; only the response is discarded.
                    if (mem_ready) begin
                        state      <= IDLE;
                        drop_fetch <= 1'b0;
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        mem_type   <= '0;
                        mem_addr   <= '0;
                        mem_wdata  <= '0;
                    end
                end
                DM_BUSY: begin
                    if (mem_ready) begin
                        state     <= IDLE;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_type  <= '0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a wait-state memory model answers the port and
// expected transactions are queued when requests are driven, then popped on each ready pulse.
module tb_mem_port_arbiter;

    localparam int ADDR_W       = 64;
    localparam int DATA_W       = 64;
    localparam int STARVE_LIMIT = 4;

    logic              clk;
    logic              rst_n;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_ready;
    logic [DATA_W-1:0] if_rdata;
    logic              dm_req;
    logic              dm_we;
    logic [2:0]        dm_type;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_ready;
    logic [DATA_W-1:0] dm_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [2:0]        mem_type;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    typedef struct packed {
        logic        is_if;
        logic [63:0] addr;
        logic        we;
        logic [2:0]  typ;
        logic [63:0] wdata;
        logic [63:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] mem_array [logic [63:0]];
    int          wait_states;
    int          wcnt;
    int          checks;
    int          failures;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .if_req(if_req),
        .if_addr(if_addr),
        .if_flush(if_flush),
        .if_ready(if_ready),
        .if_rdata(if_rdata),
        .dm_req(dm_req),
        .dm_we(dm_we),
        .dm_type(dm_type),
        .dm_addr(dm_addr),
        .dm_wdata(dm_wdata),
        .dm_ready(dm_ready),
        .dm_rdata(dm_rdata),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_type(mem_type),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] mem_lookup(input logic [63:0] a);
        if (mem_array.exists(a)) return mem_array[a];
        return {a[31:0] ^ 32'hC0DE_0000, ~a[31:0]};
    endfunction

    // Memory model: answers mem_req after wait_states extra cycles, ready for one cycle.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        wcnt      = 0;
        forever begin
            @(negedge clk);
            if (!rst_n || mem_ready) begin
                mem_ready = 1'b0;
                mem_rdata = '0;
                wcnt      = 0;
            end else if (mem_req) begin
                if (wcnt >= wait_states) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem_lookup(mem_addr);
                end else begin
                    wcnt++;
                end
            end
        end
    end

    task automatic test_reset_state();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || if_ready !== 1'b0 || dm_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl mem_req=%b mem_we=%b if_ready=%b dm_ready=%b required all 0",
                     mem_req, mem_we, if_ready, dm_ready);
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== '0 || mem_type !== 3'b000) begin
            failures++;
            $display("FAIL reset_fields addr=%h wdata=%h type=%b required all 0",
                     mem_addr, mem_wdata, mem_type);
        end
        rst_n = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic test_single_load();
        exp_t e;
        int   pulses;
        int   ready_cyc;
        wait_states = 2;
        mem_array[64'h1000] = 64'hDEAD;
        e.is_if = 1'b0; e.addr = 64'h1000; e.we = 1'b0; e.typ = 3'b011;
        e.wdata = '0;   e.rdata = 64'hDEAD;
        exp_q.push_back(e);
        dm_req = 1'b1; dm_we = 1'b0; dm_type = 3'b011; dm_addr = 64'h1000; dm_wdata = '0;
        pulses = 0;
        ready_cyc = -1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (if_ready !== 1'b0) begin
                failures++;
                $display("FAIL load_if_ready cycle=%0d if_ready=%b required 0", c, if_ready);
            end
            if (mem_req === 1'b1) begin
                checks++;
                if (mem_addr !== 64'h1000 || mem_we !== 1'b0 || mem_type !== 3'b011) begin
                    failures++;
                    $display("FAIL load_fields addr=%h we=%b type=%b required addr=1000 we=0 type=011",
                             mem_addr, mem_we, mem_type);
                end
            end
            if (dm_ready === 1'b1) begin
                pulses++;
                if (ready_cyc < 0) ready_cyc = c;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL load_extra_ready cycle=%0d got dm_ready=1 required 0", c);
                end else begin
                    e = exp_q.pop_front();
                    if (dm_rdata !== e.rdata) begin
                        failures++;
                        $display("FAIL load_rdata got=%h required=%h", dm_rdata, e.rdata);
                    end
                end
                dm_req = 1'b0;
            end
        end
        checks++;
        if (pulses != 1 || ready_cyc != 3) begin
            failures++;
            $display("FAIL load_pulse pulses=%0d at_cycle=%0d required 1 at 3", pulses, ready_cyc);
        end
        exp_q.delete();
    endtask

    task automatic test_contention();
        exp_t        e;
        exp_t        got;
        int          cnt_model;
        logic [63:0] ia;
        logic [63:0] da;
        wait_states = 0;
        cnt_model = 0;
        ia = 64'h400;
        da = 64'h8000;
        for (int g = 0; g < 10; g++) begin
            if (cnt_model == STARVE_LIMIT) begin
                e.is_if = 1'b1; e.addr = ia; e.typ = 3'b110;
                ia = ia + 64'd4;
                cnt_model = 0;
            end else begin
                e.is_if = 1'b0; e.addr = da; e.typ = 3'b010;
                da = da + 64'd8;
                cnt_model++;
            end
            e.we = 1'b0;
            e.wdata = '0;
            e.rdata = mem_lookup(e.addr);
            exp_q.push_back(e);
        end
        if_req = 1'b1; if_addr = 64'h400;
        dm_req = 1'b1; dm_we = 1'b0; dm_type = 3'b010; dm_addr = 64'h8000; dm_wdata = '0;
        for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (if_ready === 1'b1 && dm_ready === 1'b1) begin
                failures++;
                $display("FAIL contention_both_ready cycle=%0d if_ready=1 dm_ready=1 required one", c);
            end
            if (if_ready === 1'b1 || dm_ready === 1'b1) begin
                got = exp_q.pop_front();
                checks++;
                if (if_ready !== got.is_if || mem_addr !== got.addr || mem_type !== got.typ ||
                    mem_we !== got.we || mem_wdata !== got.wdata) begin
                    failures++;
                    $display("FAIL contention_grant left=%0d got if=%b addr=%h type=%b required if=%b addr=%h type=%b",
                             exp_q.size(), if_ready, mem_addr, mem_type, got.is_if, got.addr, got.typ);
                end
                checks++;
                if ((if_ready ? if_rdata : dm_rdata) !== got.rdata) begin
                    failures++;
                    $display("FAIL contention_rdata got=%h required=%h",
                             (if_ready ? if_rdata : dm_rdata), got.rdata);
                end
                if (if_ready === 1'b1) if_addr = if_addr + 64'd4;
                else dm_addr = dm_addr + 64'd8;
                if (exp_q.size() == 0) begin
                    if_req = 1'b0;
                    dm_req = 1'b0;
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL contention_timeout outstanding=%0d required 0", exp_q.size());
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        exp_q.delete();
        @(negedge clk);
        #1;
    endtask

    task automatic test_flush();
        exp_t e;
        logic seen;
        wait_states = 2;
        e.is_if = 1'b1; e.addr = 64'h200; e.we = 1'b0; e.typ = 3'b110;
        e.wdata = '0;   e.rdata = mem_lookup(64'h200);
        exp_q.push_back(e);
        if_req = 1'b1; if_addr = 64'h80; if_flush = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle_block mem_req=%b required 0", mem_req);
        end
        if_flush = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 5 && !seen; c++) begin
            @(negedge clk);
            #1;
            if (mem_req === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || mem_addr !== 64'h80 || mem_type !== 3'b110) begin
            failures++;
            $display("FAIL flush_first_grant seen=%b addr=%h type=%b required 1 80 110",
                     seen, mem_addr, mem_type);
        end
        if_flush = 1'b1;
        if_addr = 64'h200;
        @(negedge clk);
        #1;
        if_flush = 1'b0;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (dm_ready !== 1'b0) begin
                failures++;
                $display("FAIL flush_dm_ready got=%b required 0", dm_ready);
            end
            if (if_ready === 1'b1) begin
                e = exp_q.pop_front();
                checks++;
                if (mem_addr !== e.addr || if_rdata !== e.rdata) begin
                    failures++;
                    $display("FAIL flush_refetch addr=%h rdata=%h required addr=%h rdata=%h",
                             mem_addr, if_rdata, e.addr, e.rdata);
                end
                if_req = 1'b0;
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL flush_timeout outstanding=%0d required 0", exp_q.size());
        end
        if_req = 1'b0;
        exp_q.delete();
        @(negedge clk);
        #1;
    endtask

    task automatic test_store();
        exp_t e;
        int   pulses;
        wait_states = 1;
        e.is_if = 1'b0; e.addr = 64'h2000; e.we = 1'b1; e.typ = 3'b010;
        e.wdata = 64'h1234; e.rdata = '0;
        exp_q.push_back(e);
        dm_req = 1'b1; dm_we = 1'b1; dm_type = 3'b010; dm_addr = 64'h2000; dm_wdata = 64'h1234;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #1;
            if (mem_req === 1'b1 && exp_q.size() > 0) begin
                checks++;
                if (mem_we !== exp_q[0].we || mem_wdata !== exp_q[0].wdata ||
                    mem_type !== exp_q[0].typ || mem_addr !== exp_q[0].addr) begin
                    failures++;
                    $display("FAIL store_fields we=%b wdata=%h type=%b addr=%h required 1 1234 010 2000",
                             mem_we, mem_wdata, mem_type, mem_addr);
                end
            end
            if (dm_ready === 1'b1) begin
                pulses++;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                dm_req = 1'b0;
                dm_we = 1'b0;
            end
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL store_pulse got=%0d required 1", pulses);
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   cyc [2];
        int   n;
        wait_states = 0;
        for (int i = 0; i < 2; i++) begin
            e.is_if = 1'b1; e.addr = 64'(i * 4); e.we = 1'b0; e.typ = 3'b110;
            e.wdata = '0;   e.rdata = mem_lookup(64'(i * 4));
            exp_q.push_back(e);
        end
        if_req = 1'b1;
        if_addr = 64'h0;
        n = 0;
        cyc[0] = -1;
        cyc[1] = -1;
        for (int c = 0; c < 12 && exp_q.size() > 0; c++) begin
            @(negedge clk);
            #1;
            if (if_ready === 1'b1) begin
                e = exp_q.pop_front();
                checks++;
                if (mem_addr !== e.addr || if_rdata !== e.rdata) begin
                    failures++;
                    $display("FAIL b2b_fetch addr=%h rdata=%h required addr=%h rdata=%h",
                             mem_addr, if_rdata, e.addr, e.rdata);
                end
                if (n < 2) cyc[n] = c;
                n++;
                if_addr = 64'h4;
                if (exp_q.size() == 0) if_req = 1'b0;
            end
        end
        checks++;
        if (n != 2 || (cyc[1] - cyc[0]) != 2) begin
            failures++;
            $display("FAIL b2b_spacing pulses=%0d gap=%0d required 2 pulses gap 2", n, cyc[1] - cyc[0]);
        end
        if_req = 1'b0;
        exp_q.delete();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        logic seen;
        wait_states = 1;
        dm_req = 1'b1; dm_we = 1'b0; dm_type = 3'b011; dm_addr = 64'h3000; dm_wdata = '0;
        seen = 1'b0;
        for (int c = 0; c < 6 && !seen; c++) begin
            @(negedge clk);
            #1;
            if (dm_ready === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || mem_req !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_setup dm_ready=%b mem_req=%b required 1 1", seen, mem_req);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || dm_ready !== 1'b0 || mem_addr !== '0 || mem_type !== 3'b000) begin
            failures++;
            $display("FAIL reset_mid mem_req=%b dm_ready=%b addr=%h type=%b required 0 0 0 0",
                     mem_req, dm_ready, mem_addr, mem_type);
        end
        dm_req = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (mem_req !== 1'b0 || dm_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_idle mem_req=%b dm_ready=%b required 0 0", mem_req, dm_ready);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        wait_states = 0;
        rst_n = 1'b0;
        if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        dm_req = 1'b0; dm_we = 1'b0; dm_type = '0; dm_addr = '0; dm_wdata = '0;
        test_reset_state();
        test_single_load();
        test_contention();
        test_flush();
        test_store();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
